reset_sequencer: RTL and testbench

Parametrised reset generator for the machine top level: watches NUM_SRC asynchronous event lines (upload finished, OSD button, CPU error, …) plus a synchronous software request, and drives a stretched, active-high machine reset. It replaces the fixed three-source, 16-cycle stretcher with the following:

- per-source edge polarity
- retriggering during the pulse
- a post-reset hold-off window
- power-on reset
- an optional cause/event log readable by the OSD or user_io status path

---
 rtl/reset_sequencer.sv | 161 ++++++++++++++++
 tb/tb_reset_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Stretched machine reset generator: power-on stretch, per-source edge triggers, retrigger, hold-off.
// Define RESET_CAUSE_EN to implement the sticky cause register and the episode counter.
//
// state      | meaning
// ST_POR     | power-on stretch after res_n release; edge detection suppressed
// ST_ASSERT  | res high; triggers restart the pulse counter
// ST_HOLDOFF | res low, busy high; triggers discarded
// ST_IDLE    | waiting for an event or sw_req
module reset_sequencer #(
    parameter int unsigned        NUM_SRC     = 3,
    parameter logic [NUM_SRC-1:0] EDGE_MASK   = 3'b110,
    parameter int unsigned        PULSE_LEN   = 16,
    parameter int unsigned        SYNC_STAGES = 2,
    parameter int unsigned        HOLDOFF     = 0
) (
    input  logic               clk,
    input  logic               res_n,
    input  logic [NUM_SRC-1:0] src_in,
    input  logic               sw_req,
    input  logic               cause_clr,
    output logic               res,
    output logic               busy,
    output logic [NUM_SRC+1:0] cause,
    output logic [7:0]         res_count
);

    typedef enum logic [1:0] {ST_POR, ST_ASSERT, ST_HOLDOFF, ST_IDLE} state_t;

    localparam logic [7:0] PULSE_TC = 8'(PULSE_LEN - 1);
    localparam logic [7:0] HOLD_TC  = 8'(HOLDOFF - 1);

    state_t                               state_q, state_d;
    logic [7:0]                           cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0][NUM_SRC-1:0]  sync_q, sync_d;
    logic [NUM_SRC-1:0]                   prev_q, prev_d;
    logic [NUM_SRC-1:0]                   ev_q, ev_d;
    logic                                 sw_q, sw_d;
    logic                                 res_q, res_d;
    logic                                 busy_q, busy_d;

    logic [NUM_SRC-1:0] sync_last;
    logic [NUM_SRC-1:0] det;
    logic               trig;
    logic [NUM_SRC+1:0] set_bits;
    logic               bump;

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], src_in};
        sync_last = sync_q[SYNC_STAGES-1];
        prev_d    = sync_last;
        det       = (EDGE_MASK & sync_last & ~prev_q) | (~EDGE_MASK & ~sync_last & prev_q);
        // prev keeps tracking during POR so power-up levels never look like edges
        ev_d      = (state_q == ST_POR) ? '0 : det;
        sw_d      = sw_req;
        trig      = (|ev_q) | sw_q;

        state_d  = state_q;
        cnt_d    = cnt_q;
        set_bits = '0;
        bump     = 1'b0;

        case (state_q)
            ST_POR: begin
                if (cnt_q == PULSE_TC) begin
                    cnt_d   = '0;
                    state_d = (HOLDOFF == 0) ? ST_IDLE : ST_HOLDOFF;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_ASSERT: begin
                if (trig) begin
                    cnt_d    = '0;
                    set_bits = {ev_q, sw_q, 1'b0};
                end else if (cnt_q == PULSE_TC) begin
                    cnt_d   = '0;
                    state_d = (HOLDOFF == 0) ? ST_IDLE : ST_HOLDOFF;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_HOLDOFF: begin
                if (cnt_q == HOLD_TC) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                if (trig) begin
                    cnt_d    = '0;
                    state_d  = ST_ASSERT;
                    set_bits = {ev_q, sw_q, 1'b0};
                    bump     = 1'b1;
                end
            end
        endcase

        res_d  = (state_d == ST_POR) || (state_d == ST_ASSERT);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q <= ST_POR;
            cnt_q   <= '0;
            sync_q  <= '0;
            prev_q  <= '0;
            ev_q    <= '0;
            sw_q    <= 1'b0;
            res_q   <= 1'b1;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            ev_q    <= ev_d;
            sw_q    <= sw_d;
            res_q   <= res_d;
            busy_q  <= busy_d;
        end
    end

    assign res  = res_q;
    assign busy = busy_q;

`ifdef RESET_CAUSE_EN
    logic [NUM_SRC+1:0] cause_q, cause_d;
    logic [7:0]         res_count_q, res_count_d;

    // a set landing in the same cycle as cause_clr survives the clear
    always_comb begin
        cause_d     = (cause_clr ? '0 : cause_q) | set_bits;
        res_count_d = res_count_q;
        if (bump && (res_count_q != 8'hFF)) begin
            res_count_d = res_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            cause_q     <= {{(NUM_SRC+1){1'b0}}, 1'b1};
            res_count_q <= '0;
        end else begin
            cause_q     <= cause_d;
            res_count_q <= res_count_d;
        end
    end

    assign cause     = cause_q;
    assign res_count = res_count_q;
`else
    logic unused_cause;
    assign unused_cause = ^{cause_clr, set_bits, bump};
    assign cause        = '0;
    assign res_count    = '0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: timestamp-style model plus directed episode checks.
module tb_reset_sequencer;

    localparam int         NS = 3;
    localparam logic [2:0] EM = 3'b110;
    localparam int         PL = 16;
    localparam int         SS = 2;
    localparam int         HO = 8;
`ifdef RESET_CAUSE_EN
    localparam bit CAUSE_EN = 1'b1;
`else
    localparam bit CAUSE_EN = 1'b0;
`endif

    logic       clk       = 1'b0;
    logic       res_n     = 1'b0;
    logic       sw_req    = 1'b0;
    logic       cause_clr = 1'b0;
    logic [2:0] src_in    = 3'b001;
    logic       res;
    logic       busy;
    logic [4:0] cause;
    logic [7:0] res_count;

    int total = 0;
    int bad   = 0;

    reset_sequencer #(
        .NUM_SRC(NS), .EDGE_MASK(EM), .PULSE_LEN(PL), .SYNC_STAGES(SS), .HOLDOFF(HO)
    ) dut (
        .clk(clk), .res_n(res_n), .src_in(src_in), .sw_req(sw_req), .cause_clr(cause_clr),
        .res(res), .busy(busy), .cause(cause), .res_count(res_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int ec(input int v);
        return CAUSE_EN ? v : 0;
    endfunction

    // Model: res stays high for m_rem more cycles, busy also while m_hold > 0.
    // A src change sampled at edge k acts at edge k+SS+1; sw_req sampled at k acts at k+1.
    int         m_rem   = PL;
    int         m_hold  = 0;
    int         m_cnt   = 0;
    bit         m_por   = 1'b1;
    bit         m_por_d = 1'b1;
    logic [4:0] m_cause = 5'b00001;
    logic       sw_h    = 1'b0;
    logic [2:0] src_h [4] = '{default: 3'b000};

    always @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            m_rem   = PL;
            m_hold  = 0;
            m_cnt   = 0;
            m_por   = 1'b1;
            m_por_d = 1'b1;
            m_cause = 5'b00001;
            sw_h    = 1'b0;
            for (int i = 0; i < 4; i++) src_h[i] = 3'b000;
        end else begin
            logic [2:0] nw, od, ev;
            logic       t, acc;
            nw  = src_h[SS];
            od  = src_h[SS+1];
            ev  = m_por_d ? 3'b000 : ((EM & nw & ~od) | (~EM & ~nw & od));
            t   = (|ev) | sw_h;
            acc = 1'b0;
            m_por_d = m_por;
            if (m_rem > 0) begin
                if (!m_por && t) begin
                    m_rem = PL;
                    acc   = 1'b1;
                end else begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_hold = HO;
                        m_por  = 1'b0;
                    end
                end
            end else if (m_hold > 0) begin
                m_hold--;
            end else if (t) begin
                m_rem = PL;
                acc   = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end
            if (cause_clr) m_cause = 5'b00000;
            if (acc) m_cause = m_cause | {ev, sw_h, 1'b0};
            for (int i = 3; i > 0; i--) src_h[i] = src_h[i-1];
            src_h[0] = src_in;
            sw_h     = sw_req;
        end
    end

    always @(negedge clk) begin
        chk("res", int'(res), int'(m_rem > 0));
        chk("busy", int'(busy), int'((m_rem > 0) || (m_hold > 0)));
        chk("cause", int'(cause), ec(int'(m_cause)));
        chk("res_count", int'(res_count), ec(m_cnt));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_res(input int bound, output int n);
        n = 0;
        do begin step(); n++; end while (!res && n < bound);
    endtask

    task automatic wait_low_res(input int bound, output int n);
        n = 0;
        do begin step(); n++; end while (res && n < bound);
    endtask

    task automatic wait_idle(input int bound, output int n);
        n = 0;
        do begin step(); n++; end while (busy && n < bound);
    endtask

    initial begin
        int n;
        // power-up with src0 already high
        repeat (3) @(posedge clk);
        #1;
        chk("rst_res", int'(res), 1);
        chk("rst_busy", int'(busy), 1);
        chk("rst_cnt", int'(res_count), 0);
        chk("rst_cause", int'(cause), ec(1));
        res_n = 1'b1;
        wait_low_res(40, n);
        chk("por_len", n, 16);
        wait_idle(40, n);
        chk("por_holdoff", n, 8);
        chk("por_cause", int'(cause), ec(5'b00001));

        // falling edge on src0
        repeat (3) step();
        src_in = 3'b000;
        wait_res(20, n);
        chk("src0_lat", n, 4);
        wait_low_res(40, n);
        chk("src0_len", n, 16);
        chk("src0_cnt", int'(res_count), ec(1));
        chk("src0_cause", int'(cause), ec(5'b00101));
        wait_idle(20, n);
        chk("src0_holdoff", n, 8);

        // src1 rise, then sw_req lands in pulse cycle 10
        step();
        src_in = 3'b010;
        wait_res(20, n);
        chk("src1_lat", n, 4);
        repeat (8) step();
        sw_req = 1'b1;
        step();
        sw_req = 1'b0;
        wait_low_res(40, n);
        chk("retrig_len", n + 9, 26);
        chk("retrig_cnt", int'(res_count), ec(2));
        chk("retrig_cause", int'(cause), ec(5'b01111));

        // error edge inside hold-off is dropped, the next one after it is taken
        repeat (3) step();
        src_in = 3'b110;
        repeat (2) step();
        src_in = 3'b010;
        repeat (2) step();
        chk("ho_busy_in", int'(busy), 1);
        chk("ho_res", int'(res), 0);
        step();
        chk("ho_busy_out", int'(busy), 0);
        src_in = 3'b110;
        wait_res(20, n);
        chk("ho_lat", n, 4);
        chk("ho_cnt", int'(res_count), ec(3));
        chk("ho_cause", int'(cause), ec(5'b11111));
        wait_low_res(40, n);
        chk("ho_len", n, 16);
        wait_idle(20, n);

        // cause_clr and sw_req together
        step();
        cause_clr = 1'b1;
        sw_req    = 1'b1;
        step();
        cause_clr = 1'b0;
        sw_req    = 1'b0;
        wait_res(20, n);
        chk("race_lat", n, 1);
        chk("race_cause", int'(cause), ec(5'b00010));
        chk("race_cnt", int'(res_count), ec(4));

        // async reset in pulse cycle 5
        repeat (4) step();
        #2 res_n = 1'b0;
        #2;
        chk("abort_res", int'(res), 1);
        chk("abort_busy", int'(busy), 1);
        chk("abort_cnt", int'(res_count), 0);
        chk("abort_cause", int'(cause), ec(1));
        res_n = 1'b1;
        wait_low_res(40, n);
        chk("por2_len", n, 16);
        wait_idle(20, n);
        chk("por2_holdoff", n, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
